dct_coef_accum: RTL and testbench

Consumes one 8x8 pixel block in raster order and computes a single 2D-DCT coefficient for a fixed (k1,k2) pair. It drives the (n1,n2) index of the current pixel to the matching cosine LUT. It takes the LUT's signed cos_term back in the same cycle and multiply-accumulates it. After the 64th pixel it emits the scaled, saturated coefficient. One instance per (k1,k2) sits between the pixel block buffer and the coefficient quantiser.

---
 rtl/dct_coef_accum_if.sv | 26 ++
 rtl/dct_coef_accum.sv | 150 +++++++++++++++
 tb/tb_dct_coef_accum.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct_coef_accum_if.sv
// Pixel-in / LUT / coefficient-out bundle for dct_coef_accum.
// master: the side that feeds pixels, answers the LUT and takes the coefficient.
// slave:  the accumulator block itself.
interface dct_coef_accum_if #(
  parameter int unsigned OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_pixel;
  logic [2:0]       cos_n1;
  logic [2:0]       cos_n2;
  logic [31:0]      cos_term;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_coef;

  modport master (
    output in_valid, in_pixel, cos_term, out_ready,
    input  in_ready, cos_n1, cos_n2, out_valid, out_coef
  );

  modport slave (
    input  in_valid, in_pixel, cos_term, out_ready,
    output in_ready, cos_n1, cos_n2, out_valid, out_coef
  );
endinterface

// File: rtl/dct_coef_accum.sv
// Single 2D-DCT coefficient accumulator for one fixed (k1,k2).
// Takes an 8x8 block in raster order, looks up the cosine term for each pixel's
// (n1,n2) through the LUT, multiply-accumulates, and emits the scaled and
// saturated coefficient one clock after the 64th pixel.
// Optional build macro: DCT_LEVEL_SHIFT_EN subtracts 128 from each pixel before
// the multiply.
module dct_coef_accum #(
  parameter int unsigned SHIFT = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  dct_coef_accum_if.slave   bus
);

  localparam logic signed [31:0] CoefMax = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] CoefMin = -(32'sd1 <<< (OUT_W - 1));

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [5:0]        idx_q, idx_d;
  logic signed [31:0] acc_q, acc_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_coef_q, out_coef_d;

  logic signed [8:0]  pix_s;
  logic signed [31:0] pix_ext;
  logic signed [31:0] product;
  logic signed [31:0] acc_sum;
  logic               in_hs;

  // Floor shift down to the LUT scale, then clamp to the output range.
  function automatic logic [OUT_W-1:0] scale_sat(input logic signed [31:0] a);
    logic signed [31:0] s;
    s = a >>> SHIFT;
    if (s > CoefMax) begin
      return CoefMax[OUT_W-1:0];
    end else if (s < CoefMin) begin
      return CoefMin[OUT_W-1:0];
    end else begin
      return s[OUT_W-1:0];
    end
  endfunction

  // Pixel operand, optionally level-shifted to -128..127.
  always_comb begin
`ifdef DCT_LEVEL_SHIFT_EN
    pix_s = $signed({1'b0, bus.in_pixel}) - 9'sd128;
`else
    pix_s = $signed({1'b0, bus.in_pixel});
`endif
    pix_ext = 32'(pix_s);
    // 32-bit context keeps only the low word of the product.
    product = pix_ext * $signed(bus.cos_term);
    acc_sum = acc_q + product;
  end

  // Ready is a function of state only; held low while reset is asserted.
  always_comb begin
    bus.in_ready = rst_n && (state_q != StDone);
    in_hs        = bus.in_valid && bus.in_ready;
  end

  // LUT index and registered results.
  always_comb begin
    bus.cos_n1    = idx_q[5:3];
    bus.cos_n2    = idx_q[2:0];
    bus.out_valid = out_valid_q;
    bus.out_coef  = out_coef_q;
  end

  // Next-state and datapath updates; clear overrides every handshake.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_coef_d  = out_coef_q;

    unique case (state_q)
      StIdle: begin
        if (in_hs) begin
          acc_d   = product;
          idx_d   = 6'd1;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (in_hs) begin
          acc_d = acc_sum;
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd63) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_coef_d  = scale_sat(acc_sum);
          end
        end
      end
      StDone: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (clear) begin
      idx_d       = '0;
      acc_d       = '0;
      out_valid_d = 1'b0;
      state_d     = StIdle;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_coef_q  <= '0;
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_coef_q  <= out_coef_d;
    end
  end

endmodule

// File: tb/tb_dct_coef_accum.sv
// Directed bench for dct_coef_accum: supplies a combinational cosine LUT,
// streams 8x8 blocks and checks coefficients, indexing, backpressure,
// clear and mid-block reset.
module tb_dct_coef_accum;

`ifdef DCT_LEVEL_SHIFT_EN
  localparam longint ImpCoef = 123;
`else
  localparam longint ImpCoef = -246;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clear;

  int checks = 0;
  int errors = 0;

  int lut [64];
  int pix [64];

  dct_coef_accum_if #(.OUT_W(16)) bus ();

  dct_coef_accum #(
    .SHIFT(8),
    .OUT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.cos_term = lut[{bus.cos_n1, bus.cos_n2}];

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer one pixel at a negedge; returns at the negedge after its handshake.
  task automatic send(input int p);
    int n;
    n = 0;
    bus.in_pixel = 8'(p);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 100) else begin
      errors++;
      $error("FAIL ready_timeout observed=%0d expected=<100", n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Stream pix[] through the DUT; ends at the negedge where out_valid rises.
  task automatic run_block(input bit gap, input bit chk_idx);
    for (int k = 0; k < 64; k++) begin
      if (chk_idx) begin
        check("n1_pre", bus.cos_n1, k / 8);
        check("n2_pre", bus.cos_n2, k % 8);
      end
      if (k == 63) check("valid_before_last", bus.out_valid, 0);
      send(pix[k]);
      if (gap && k != 63) begin
        @(negedge clk);
        if (chk_idx) begin
          check("n1_idle", bus.cos_n1, (k + 1) / 8);
          check("n2_idle", bus.cos_n2, (k + 1) % 8);
        end
      end
    end
  endtask

  function automatic longint golden();
    longint s;
    longint p;
    longint q;
    s = 0;
    for (int k = 0; k < 64; k++) begin
`ifdef DCT_LEVEL_SHIFT_EN
      p = longint'(pix[k]) - 128;
`else
      p = longint'(pix[k]);
`endif
      s += p * longint'(lut[k]);
    end
    q = s >>> 8;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic lut_pattern();
    for (int k = 0; k < 64; k++) lut[k] = ((k * 73) % 401) - 200;
  endtask

  task automatic impulse_block();
    lut_pattern();
    lut[24] = -246;
`ifdef DCT_LEVEL_SHIFT_EN
    for (int k = 0; k < 64; k++) pix[k] = 128;
    pix[24] = 0;
`else
    for (int k = 0; k < 64; k++) pix[k] = 0;
    pix[24] = 255;
`endif
  endtask

  // With out_ready high, out_valid must be one cycle wide.
  task automatic expect_pulse(input string tag, input longint coef);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_coef"}, $signed(bus.out_coef), coef);
    @(negedge clk);
    check({tag, "_valid_drop"}, bus.out_valid, 0);
    check({tag, "_ready_back"}, bus.in_ready, 1);
  endtask

  initial begin
    longint exp_c;
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = 8'd0;
    bus.out_ready = 1'b1;
    lut_pattern();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_coef", $signed(bus.out_coef), 0);
    check("rst_n1", bus.cos_n1, 0);
    check("rst_n2", bus.cos_n2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);

`ifdef DCT_LEVEL_SHIFT_EN
    // Mid-grey block cancels to zero
    for (int k = 0; k < 64; k++) pix[k] = 128;
    run_block(1'b0, 1'b0);
    expect_pulse("ls_const128", 0);

    // Single dark pixel at (3,0)
    impulse_block();
    run_block(1'b0, 1'b0);
    check("ls_imp_acc", $signed(dut.acc_q), 31488);
    expect_pulse("ls_impulse", 123);
`else
    // Zero block
    for (int k = 0; k < 64; k++) pix[k] = 0;
    run_block(1'b0, 1'b0);
    expect_pulse("zero", 0);

    // Impulse at (3,0): 255 * -246 = -62730, floor(/256) = -246
    impulse_block();
    run_block(1'b0, 1'b0);
    check("imp_acc", $signed(dut.acc_q), -62730);
    expect_pulse("impulse", -246);

    // Saturation both ways: 64*255*1000 >> 8 = 63750
    for (int k = 0; k < 64; k++) begin
      pix[k] = 255;
      lut[k] = 1000;
    end
    run_block(1'b0, 1'b0);
    expect_pulse("sat_pos", 32767);
    for (int k = 0; k < 64; k++) lut[k] = -1000;
    run_block(1'b0, 1'b0);
    expect_pulse("sat_neg", -32768);
`endif

    // Indexing with in_valid every other cycle
    for (int k = 0; k < 64; k++) begin
      pix[k] = (k * 37 + 11) % 256;
      lut[k] = ((k * 53) % 511) - 255;
    end
    exp_c = golden();
    run_block(1'b1, 1'b1);
    expect_pulse("index", exp_c);

    // Backpressure: hold out_ready low, offer pixels that must not be taken
    impulse_block();
    bus.out_ready = 1'b0;
    run_block(1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_pixel = 8'd200;
      check("bp_valid", bus.out_valid, 1);
      check("bp_coef", $signed(bus.out_coef), ImpCoef);
      check("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("bp_idx_held", {bus.cos_n1, bus.cos_n2}, 0);
    check("bp_coef_held", $signed(bus.out_coef), ImpCoef);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_ready", bus.in_ready, 1);

    // Abort after 30 pixels; clear wins over a simultaneous pixel
    for (int k = 0; k < 64; k++) lut[k] = 500;
    for (int k = 0; k < 30; k++) send(255);
    check("pre_clear_idx", {bus.cos_n1, bus.cos_n2}, 30);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'd255;
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_idx", {bus.cos_n1, bus.cos_n2}, 0);
    check("clear_acc", $signed(dut.acc_q), 0);
    check("clear_valid", bus.out_valid, 0);
    impulse_block();
    run_block(1'b0, 1'b0);
    expect_pulse("after_clear", ImpCoef);

    // Clear in DONE together with out_ready
    bus.out_ready = 1'b0;
    run_block(1'b0, 1'b0);
    check("done_before_clear", bus.out_valid, 1);
    clear = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("done_clear_valid", bus.out_valid, 0);
    check("done_clear_ready", bus.in_ready, 1);
    check("done_clear_acc", $signed(dut.acc_q), 0);

    // Reset mid-block
    for (int k = 0; k < 10; k++) send(100);
    check("pre_rst_idx", {bus.cos_n1, bus.cos_n2}, 10);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_idx", {bus.cos_n1, bus.cos_n2}, 0);
    check("mid_rst_acc", $signed(dut.acc_q), 0);
    check("mid_rst_coef", $signed(bus.out_coef), 0);
    check("mid_rst_ready", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // A full block after reset is unaffected by the aborted pixels
    for (int k = 0; k < 64; k++) begin
      pix[k] = (k * 91 + 7) % 256;
      lut[k] = ((k * 29) % 300) - 150;
    end
    exp_c = golden();
    run_block(1'b0, 1'b1);
    expect_pulse("post_rst", exp_c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
